tree_add_seq: RTL and testbench

TREE_ADD_SEQ -- requirements
Module: tree_add_seq

---
 rtl/tree_add_seq_pkg.sv | 23 ++
 rtl/tree_add_seq_alu.sv | 59 +++++
 rtl/tree_add_seq.sv | 139 +++++++++++++
 tb/tb_tree_add_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tree_add_seq_pkg.sv
// tree_add_seq_pkg
//   Shared definitions for the sequential tree adder:
//   - 3-bit state encoding (IDLE=0 .. DONE=4) as localparams and an enum
//   - counter width for the optional completed-operation counter
package tree_add_seq_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADD1 = 3'd1;
  localparam logic [2:0] ST_ADD2 = 3'd2;
  localparam logic [2:0] ST_ADD3 = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    ADD1 = ST_ADD1,
    ADD2 = ST_ADD2,
    ADD3 = ST_ADD3,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/tree_add_seq_alu.sv
// tree_add_seq_alu
//   Combinational (WC+1)-bit unsigned adder shared by all three additions.
//   The operand pair is selected by the controller state.
// Ports:
//   state  in   current controller state
//   a, b   in   WA-bit captured operands   (used in ADD1)
//   c, d   in   WC-bit captured operands   (used in ADD2)
//   sum1   in   WA+1-bit partial sum       (used in ADD3)
//   sum2   in   WC+1-bit partial sum       (used in ADD3)
//   result out  WC+2-bit sum, carry kept
module tree_add_seq_alu
  import tree_add_seq_pkg::*;
#(
  parameter int WA = 4,
  parameter int WC = 8
) (
  input  state_t          state,
  input  logic [WA-1:0]   a,
  input  logic [WA-1:0]   b,
  input  logic [WC-1:0]   c,
  input  logic [WC-1:0]   d,
  input  logic [WA:0]     sum1,
  input  logic [WC:0]     sum2,
  output logic [WC+1:0]   result
);

  localparam int XW = WC + 1;
  localparam int RW = WC + 2;

  logic [WC:0] x;
  logic [WC:0] y;

  always_comb begin
    x = '0;
    y = '0;
    case (state)
      ADD1: begin
        x = XW'(a);
        y = XW'(b);
      end
      ADD2: begin
        x = XW'(c);
        y = XW'(d);
      end
      ADD3: begin
        // WC >= WA, so sum1 always fits the adder width.
        x = XW'(sum1);
        y = sum2;
      end
      default: begin
        x = '0;
        y = '0;
      end
    endcase
  end

  assign result = RW'(x) + RW'(y);

endmodule

// File: rtl/tree_add_seq.sv
// tree_add_seq
//   Sequential tree adder: sum1=a+b, sum2=c+d, sum3=sum1+sum2 computed
//   over three cycles on one shared adder, with valid/ready handshakes
//   on both sides. Latency is 3 cycles from the accept edge; minimum
//   initiation interval is 5 cycles.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   ADD1  | sum1 <= a+b
//   ADD2  | sum2 <= c+d
//   ADD3  | sum3 <= sum1+sum2
//   DONE  | results valid, held until out_ready
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   a, b / c, d          WA / WC-bit unsigned operands
//   in_valid, in_ready   operand handshake
//   sum1, sum2, sum3     registered results (WA+1, WC+1, WC+2 bits)
//   out_valid, out_ready result handshake
//   busy                 high whenever not IDLE
//   op_count             16-bit wrapping count of completed results,
//                        present only with TREE_ADD_SEQ_CNT_EN defined
module tree_add_seq
  import tree_add_seq_pkg::*;
#(
  parameter int WA = 4,
  parameter int WC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WA-1:0]     a,
  input  logic [WA-1:0]     b,
  input  logic [WC-1:0]     c,
  input  logic [WC-1:0]     d,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WA:0]       sum1,
  output logic [WC:0]       sum2,
  output logic [WC+1:0]     sum3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef TREE_ADD_SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0]  op_count
`endif
);

  state_t        state;
  logic [WA-1:0] a_q;
  logic [WA-1:0] b_q;
  logic [WC-1:0] c_q;
  logic [WC-1:0] d_q;
  logic [WC+1:0] alu_res;

  tree_add_seq_alu #(
    .WA (WA),
    .WC (WC)
  ) u_alu (
    .state  (state),
    .a      (a_q),
    .b      (b_q),
    .c      (c_q),
    .d      (d_q),
    .sum1   (sum1),
    .sum2   (sum2),
    .result (alu_res)
  );

  // Handshake outputs are registered alongside the state so they change
  // on the same edge as the transition that implies them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      sum1      <= '0;
      sum2      <= '0;
      sum3      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            c_q      <= c;
            d_q      <= d;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ADD1;
          end
        end
        ADD1: begin
          sum1  <= alu_res[WA:0];
          state <= ADD2;
        end
        ADD2: begin
          sum2  <= alu_res[WC:0];
          state <= ADD3;
        end
        ADD3: begin
          sum3      <= alu_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef TREE_ADD_SEQ_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tree_add_seq.sv
module tb_tree_add_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a, b;
  logic [7:0] c, d;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid, busy;
  logic [4:0] sum1;
  logic [8:0] sum2;
  logic [9:0] sum3;
`ifdef TREE_ADD_SEQ_CNT_EN
  logic [15:0] op_count;
`endif

  tree_add_seq #(.WA(4), .WC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum1      (sum1),
    .sum2      (sum2),
    .sum3      (sum3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef TREE_ADD_SEQ_CNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Transaction-level model: phase counts edges since accept
  // (0 = idle, 4 = result presented); sums are plain arithmetic on the
  // operands seen at the accept edge, revealed one per edge.
  int         phase = 0;
  int         done_cnt = 0;
  logic [4:0] p1, e1;
  logic [8:0] p2, e2;
  logic [9:0] p3, e3;
  logic       chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = 0;
      e1 = '0; e2 = '0; e3 = '0;
      done_cnt = 0;
    end else if (phase == 0) begin
      if (in_valid) begin
        p1 = a + b;
        p2 = c + d;
        p3 = p1 + p2;
        phase = 1;
      end
    end else if (phase < 4) begin
      if (phase == 1) e1 = p1;
      if (phase == 2) e2 = p2;
      if (phase == 3) e3 = p3;
      phase = phase + 1;
    end else if (out_ready) begin
      phase = 0;
      done_cnt = done_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out_valid", out_valid, phase == 4);
      check("cyc_in_ready", in_ready, phase == 0);
      check("cyc_busy", busy, phase != 0);
      check("cyc_sum1", sum1, e1);
      check("cyc_sum2", sum2, e2);
      check("cyc_sum3", sum3, e3);
`ifdef TREE_ADD_SEQ_CNT_EN
      check("cyc_op_count", op_count, done_cnt % 65536);
`endif
    end
  end

  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib,
                       input logic [7:0] ic, input logic [7:0] id,
                       input logic [4:0] x1, input logic [8:0] x2,
                       input logic [9:0] x3, input int stall, input bit early);
    int lat;
    check("idle_before_op", in_ready, 1);
    a = ia; b = ib; c = ic; d = id;
    in_valid  = 1'b1;
    out_ready = early;
    @(posedge clk); #1;
    // Operands change and in_valid stays high: both must be ignored.
    a = ~ia; b = ~ib; c = ~ic; d = ~id;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 3);
    check("lit_sum1", sum1, x1);
    check("lit_sum2", sum2, x2);
    check("lit_sum3", sum3, x3);
    check("model_sum3", e3, x3);
    check("in_ready_in_done", in_ready, 0);
    if (early) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("early_ready_done", out_valid, 0);
      out_ready = 1'b0;
    end else begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_out_valid", out_valid, 1);
        check("stall_sum3", sum3, x3);
        check("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("released_valid", out_valid, 0);
      check("released_in_ready", in_ready, 1);
      check("held_sum3", sum3, x3);
    end
  endtask

  initial begin
    a = '0; b = '0; c = '0; d = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("rst_sum3", sum3, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);

    do_op(4'd0,  4'd3,  8'd1,   8'd255, 5'd3,  9'd256, 10'd259, 0, 1'b0);
    do_op(4'd10, 4'd13, 8'd9,   8'd10,  5'd23, 9'd19,  10'd42,  0, 1'b0);
    do_op(4'd15, 4'd15, 8'd109, 8'd37,  5'd30, 9'd146, 10'd176, 0, 1'b0);
    do_op(4'd15, 4'd15, 8'd255, 8'd255, 5'd30, 9'd510, 10'd540, 5, 1'b0);
    do_op(4'd7,  4'd1,  8'd100, 8'd50,  5'd8,  9'd150, 10'd158, 0, 1'b1);

    // Reset while in ADD2 must abort without presenting a result.
    a = 4'd4; b = 4'd4; c = 8'd4; d = 8'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_sum1", sum1, 0);
    check("abort_sum2", sum2, 0);
    check("abort_sum3", sum3, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (5) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 0);
    end

    do_op(4'd5, 4'd6, 8'd7, 8'd8, 5'd11, 9'd15, 10'd26, 2, 1'b0);
`ifdef TREE_ADD_SEQ_CNT_EN
    // Only the op completed after the abort-reset is counted.
    check("lit_op_count", op_count, 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
